// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// Parametrised VGA scan-out engine. Divides CLOCK_50 down to a pixel
// clock-enable, walks the raster with horizontal/vertical position counters,
// issues framebuffer read addresses and re-times the returned pixel data so
// that RGB, syncs, blank, vblank and frame_start all leave the block in the
// same pixel period.
//
// Optional feature: define VGA_PIXDBL_EN to map each framebuffer word onto a
// 2x2 block of screen pixels (address = (v>>1)*(H_ACTIVE/2)+(h>>1)). Without
// the macro, addressing is 1:1 (address = v*H_ACTIVE+h).
//
// Ports:
//   CLOCK_50    in   system clock, all registers on its rising edge
//   reset       in   synchronous, active-high reset
//   fb_adr      out  framebuffer read address (ADR_W)
//   fb_q        in   framebuffer read data (PIX_W, R:G:B MSB first),
//                    valid RAM_LAT cycles after fb_adr
//   VGA_R/G/B   out  8-bit colour channels, zero during blanking
//   VGA_CLK     out  DAC latch clock, low for CLK_DIV/2 cycles after each
//                    output update, high for the rest of the pixel period
//   VGA_HS      out  horizontal sync (asserted level HS_ACT)
//   VGA_VS      out  vertical sync (asserted level VS_ACT)
//   VGA_BLANK_N out  low during blanking
//   VGA_SYNC_N  out  constant 0 (no sync on green)
//   frame_start out  one-cycle strobe when pixel (0,0) reaches the outputs
//   vblank      out  high while the output line is >= V_ACTIVE
// -----------------------------------------------------------------------------
module vga_scanout #(
    parameter int   CLK_DIV  = 5,
    parameter int   H_ACTIVE = 200,
    parameter int   H_FP     = 10,
    parameter int   H_SYNC   = 32,
    parameter int   H_BP     = 22,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic HS_ACT   = 1'b0,
    parameter logic VS_ACT   = 1'b0,
    parameter int   ADR_W    = 17,
    parameter int   PIX_W    = 24,
    parameter int   RAM_LAT  = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    output logic [ADR_W-1:0] fb_adr,
    input  logic [PIX_W-1:0] fb_q,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B,
    output logic             VGA_CLK,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic             frame_start,
    output logic             vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    // VGA_CLK rises on the edge where div_cnt becomes CLK_DIV/2, i.e. while
    // div_cnt currently holds the value one below that.
    localparam logic [DIV_W-1:0] DIV_HALF_PRE = DIV_W'(CLK_DIV / 2 - 1);

    localparam logic [H_W-1:0] H_ACT_L  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_L  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);

    // Elaboration-time guards on illegal configurations.
    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_scanout: CLK_DIV must be at least 2");
    end
    if (RAM_LAT >= CLK_DIV) begin : g_bad_lat
        $error("vga_scanout: RAM_LAT must be less than CLK_DIV");
    end
    if (PIX_W < 24) begin : g_bad_pix
        $error("vga_scanout: PIX_W must hold 24-bit R:G:B");
    end

    function automatic logic [ADR_W-1:0] pix_addr(input logic [H_W-1:0] hp,
                                                  input logic [V_W-1:0] vp);
`ifdef VGA_PIXDBL_EN
        return ADR_W'(ADR_W'(vp >> 1) * ADR_W'(H_ACTIVE / 2) + ADR_W'(hp >> 1));
`else
        return ADR_W'(ADR_W'(vp) * ADR_W'(H_ACTIVE) + ADR_W'(hp));
`endif
    endfunction

    function automatic logic sync_level(input logic on, input logic act_lvl);
        return on ? act_lvl : ~act_lvl;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             pix_ce;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    logic             active, hs_on, vs_on;

    logic vld_p1, hs_p1, vs_p1, vbl_p1, org_p1;

    assign pix_ce     = (div_cnt == DIV_LAST);
    assign active     = (h < H_ACT_L) && (v < V_ACT_L);
    assign hs_on      = (h >= HS_FIRST) && (h <= HS_LAST);
    assign vs_on      = (v >= VS_FIRST) && (v <= VS_LAST);
    assign VGA_SYNC_N = 1'b0;

    // ---- Stage 0: pixel divider, DAC clock and raster position ----
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt <= '0;
            VGA_CLK <= 1'b0;
        end else if (pix_ce) begin
            div_cnt <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == DIV_HALF_PRE) begin
                VGA_CLK <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_ce) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // ---- Stage 1: framebuffer address issue, region flags delayed ----
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            fb_adr <= '0;
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            vbl_p1 <= 1'b0;
            org_p1 <= 1'b0;
        end else if (pix_ce) begin
            fb_adr <= active ? pix_addr(h, v) : '0;
            vld_p1 <= active;
            hs_p1  <= hs_on;
            vs_p1  <= vs_on;
            vbl_p1 <= (v >= V_ACT_L);
            org_p1 <= (h == '0) && (v == '0);
        end
    end

    // ---- Stage 2: RAM data captured, all pin outputs updated together ----
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= ~HS_ACT;
            VGA_VS      <= ~VS_ACT;
            vblank      <= 1'b0;
        end else if (pix_ce) begin
            VGA_R       <= vld_p1 ? fb_q[23:16] : 8'd0;
            VGA_G       <= vld_p1 ? fb_q[15:8]  : 8'd0;
            VGA_B       <= vld_p1 ? fb_q[7:0]   : 8'd0;
            VGA_BLANK_N <= vld_p1;
            VGA_HS      <= sync_level(hs_p1, HS_ACT);
            VGA_VS      <= sync_level(vs_p1, VS_ACT);
            vblank      <= vbl_p1;
        end
    end

    // Pulse lasts exactly one CLOCK_50 cycle because pix_ce is itself a
    // single-cycle enable.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && org_p1;
        end
    end

endmodule
